exc_irq_ctrl: RTL and testbench

//  Exception/interrupt sequencer for the single-cycle LEGv8 core.

---
 rtl/exc_irq_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_irq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer: edge-captures IRQs, arbitrates lowest index, runs IDLE->ENTRY->HANDLER.
// Latency: invalid opcode redirects in the same cycle; IRQ rise at t gives ENTRY (exc/ack) at t+2.
// Backpressure: none. IRQs stay pending while masked in HANDLER; rises are never dropped except by reset.
module exc_irq_ctrl #(
  parameter int          N_IRQ      = 4,
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IRQ-1:0]         irq_req,
  input  logic                     not_an_instr,
  input  logic                     eret,
  output logic                     exc,
  output logic [63:0]              exc_vector,
  output logic                     elr_we,
  output logic                     esr_we,
  output logic [3:0]               status,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic [N_IRQ-1:0]         irq_ack,
  output logic                     in_handler,
  output logic                     fatal
);

  localparam int IDW = $clog2(N_IRQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_req_q, irq_req_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic             fatal_q, fatal_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [IDW-1:0]   win_id;
  logic             exc_c, elr_we_c, esr_we_c;
  logic [3:0]       status_c;
  logic [N_IRQ-1:0] irq_ack_c;

  // State register; reset aborts any exception in flight and drops pending IRQs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      irq_req_q <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_req_q <= irq_req_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      fatal_q   <= fatal_d;
    end
  end

  // Fixed-priority arbiter: scan from the top so the lowest pending index is the last write.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) win_id = IDW'(i);
    end
  end

  // Next state, pending bookkeeping and redirect outputs.
  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    fatal_d   = fatal_q;
    clr       = '0;
    exc_c     = 1'b0;
    elr_we_c  = 1'b0;
    esr_we_c  = 1'b0;
    status_c  = 4'b0000;
    irq_ack_c = '0;

    case (state_q)
      S_IDLE: begin
        // A faulting instruction outranks pending IRQs; they wait until after ERET.
        if (not_an_instr) begin
          exc_c    = 1'b1;
          elr_we_c = 1'b1;
          esr_we_c = 1'b1;
          status_c = 4'b0010;
          state_d  = S_HANDLER;
        end else if (|pending_q) begin
          irq_id_d = win_id;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        exc_c            = 1'b1;
        elr_we_c         = 1'b1;
        esr_we_c         = 1'b1;
        status_c         = 4'b0001;
        irq_ack_c[irq_id_q] = 1'b1;
        clr[irq_id_q]    = 1'b1;
        state_d          = S_HANDLER;
      end
      S_HANDLER: begin
        if (eret) begin
          state_d = S_IDLE;
        end else if (not_an_instr) begin
          // Fault inside the handler cannot be re-entered; flag it and keep running.
          fatal_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new rise in the same cycle as the clear keeps the line pending.
    rise      = irq_req & ~irq_req_q;
    irq_req_d = irq_req;
    pending_d = (pending_q & ~clr) | rise;
  end

  // Outputs are held low while reset is asserted.
  assign exc        = exc_c & ~reset;
  assign elr_we     = elr_we_c & ~reset;
  assign esr_we     = esr_we_c & ~reset;
  assign status     = reset ? 4'b0000 : status_c;
  assign irq_ack    = reset ? '0 : irq_ack_c;
  assign irq_id     = reset ? '0 : irq_id_q;
  assign in_handler = (state_q == S_HANDLER) & ~reset;
  assign fatal      = fatal_q & ~reset;
  assign exc_vector = EXC_VECTOR;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Bench for exc_irq_ctrl: directed scenarios followed by random traffic, all checked against a reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later, model advanced on the rising edge.
// Backpressure: not applicable; the clock always runs so every wait is bounded by the step count.
module tb_exc_irq_ctrl;

  localparam int          N   = 4;
  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

  localparam int M_IDLE    = 0;
  localparam int M_ENTRY   = 1;
  localparam int M_HANDLER = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_req = '0;
  logic         not_an_instr = 1'b0;
  logic         eret = 1'b0;
  logic         exc;
  logic [63:0]  exc_vector;
  logic         elr_we, esr_we;
  logic [3:0]   status;
  logic [1:0]   irq_id;
  logic [N-1:0] irq_ack;
  logic         in_handler;
  logic         fatal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int         m_mode  = M_IDLE;
  bit [N-1:0] m_pend  = '0;
  bit [N-1:0] m_prev  = '0;
  int         m_id    = 0;
  bit         m_fatal = 1'b0;

  // Last sampled outputs, for directed checks
  logic         s_exc, s_inh, s_fat;
  logic [3:0]   s_st;
  logic [1:0]   s_id;
  logic [N-1:0] s_ack;

  exc_irq_ctrl #(.N_IRQ(N), .EXC_VECTOR(VEC)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_req      (irq_req),
    .not_an_instr (not_an_instr),
    .eret         (eret),
    .exc          (exc),
    .exc_vector   (exc_vector),
    .elr_we       (elr_we),
    .esr_we       (esr_we),
    .status       (status),
    .irq_id       (irq_id),
    .irq_ack      (irq_ack),
    .in_handler   (in_handler),
    .fatal        (fatal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  // One clock: drive, compare against the model, then advance the model on the rising edge.
  task automatic step(input logic [N-1:0] irq, input logic nai, input logic er, input logic rst);
    logic         e_exc, e_inh, e_fat;
    logic [3:0]   e_st;
    logic [N-1:0] e_ack, rise, clr;
    int           e_id;
    @(negedge clk);
    irq_req      = irq;
    not_an_instr = nai;
    eret         = er;
    reset        = rst;
    #1;
    e_exc = 1'b0; e_st = 4'b0000; e_ack = '0; e_inh = 1'b0;
    e_id  = m_id; e_fat = m_fatal;
    if (rst) begin
      e_id  = 0;
      e_fat = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (nai) begin e_exc = 1'b1; e_st = 4'b0010; end
    end else if (m_mode == M_ENTRY) begin
      e_exc = 1'b1; e_st = 4'b0001; e_ack[m_id] = 1'b1;
    end else begin
      e_inh = 1'b1;
    end
    chk("exc",        64'(exc),        64'(e_exc));
    chk("elr_we",     64'(elr_we),     64'(e_exc));
    chk("esr_we",     64'(esr_we),     64'(e_exc));
    chk("status",     64'(status),     64'(e_st));
    chk("irq_ack",    64'(irq_ack),    64'(e_ack));
    chk("irq_id",     64'(irq_id),     64'(e_id));
    chk("in_handler", 64'(in_handler), 64'(e_inh));
    chk("fatal",      64'(fatal),      64'(e_fat));
    chk("exc_vector", exc_vector,      VEC);
    s_exc = exc; s_inh = in_handler; s_fat = fatal;
    s_st = status; s_id = irq_id; s_ack = irq_ack;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_pend = '0; m_prev = '0; m_id = 0; m_fatal = 1'b0;
    end else begin
      rise = irq & ~m_prev;
      clr  = '0;
      if (m_mode == M_IDLE) begin
        if (nai) m_mode = M_HANDLER;
        else if (m_pend != 0) begin
          for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin m_id = i; break; end
          end
          m_mode = M_ENTRY;
        end
      end else if (m_mode == M_ENTRY) begin
        clr[m_id] = 1'b1;
        m_mode = M_HANDLER;
      end else begin
        if (er) m_mode = M_IDLE;
        else if (nai) m_fatal = 1'b1;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = irq;
    end
  endtask

  initial begin
    // Reset state
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);
    chk("rst_exc", 64'(s_exc), 64'(0));
    chk("rst_inh", 64'(s_inh), 64'(0));
    chk("rst_fatal", 64'(s_fat), 64'(0));

    // T1: single IRQ, two-cycle entry latency
    step(4'b0000, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    chk("t1_no_exc_yet", 64'(s_exc), 64'(0));
    step(4'b0100, 0, 0, 0);
    chk("t1_exc", 64'(s_exc), 64'(1));
    chk("t1_ack", 64'(s_ack), 64'(4'b0100));
    chk("t1_status", 64'(s_st), 64'(4'b0001));
    chk("t1_id", 64'(s_id), 64'(2));
    step(4'b0100, 0, 0, 0);
    chk("t1_handler", 64'(s_inh), 64'(1));
    step(4'b0100, 0, 1, 0);
    // T6: held level gives no second ack, eret in IDLE ignored
    step(4'b0100, 0, 0, 0);
    chk("t6_no_reentry", 64'(s_exc), 64'(0));
    step(4'b0100, 0, 1, 0);
    chk("t6_eret_idle", 64'(s_inh), 64'(0));
    step(4'b0100, 0, 0, 0);
    chk("t6_no_ack", 64'(s_ack), 64'(0));
    step(4'b0000, 0, 0, 0);

    // T2: simultaneous IRQ1 and IRQ3
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 0);
    chk("t2_first_id", 64'(s_id), 64'(1));
    chk("t2_first_ack", 64'(s_ack), 64'(4'b0010));
    step(4'b1010, 0, 1, 0);
    step(4'b1010, 0, 0, 0);
    chk("t2_idle_gap", 64'(s_exc), 64'(0));
    step(4'b1010, 0, 0, 0);
    chk("t2_second_exc", 64'(s_exc), 64'(1));
    chk("t2_second_id", 64'(s_id), 64'(3));
    chk("t2_second_ack", 64'(s_ack), 64'(4'b1000));
    step(4'b1010, 0, 1, 0);
    step(4'b0000, 0, 0, 0);

    // T3: invalid opcode in IDLE with IRQ0 pending
    step(4'b0001, 0, 0, 0);
    step(4'b0001, 1, 0, 0);
    chk("t3_exc", 64'(s_exc), 64'(1));
    chk("t3_status", 64'(s_st), 64'(4'b0010));
    chk("t3_no_ack", 64'(s_ack), 64'(0));
    step(4'b0001, 0, 0, 0);
    chk("t3_handler", 64'(s_inh), 64'(1));
    // T4: double fault
    step(4'b0001, 1, 0, 0);
    chk("t4_no_exc", 64'(s_exc), 64'(0));
    step(4'b0001, 0, 0, 0);
    chk("t4_fatal", 64'(s_fat), 64'(1));
    step(4'b0001, 0, 1, 0);
    chk("t4_fatal_eret", 64'(s_fat), 64'(1));
    step(4'b0001, 0, 0, 0);
    chk("t4_fatal_idle", 64'(s_fat), 64'(1));
    step(4'b0001, 0, 0, 0);
    chk("t3_pend_kept", 64'(s_ack), 64'(4'b0001));
    step(4'b0001, 0, 1, 0);

    // T5: reset while in HANDLER with IRQ1/IRQ2 pending
    step(4'b0000, 1, 0, 0);
    step(4'b0110, 0, 0, 0);
    step(4'b0110, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);
    chk("t5_inh", 64'(s_inh), 64'(0));
    chk("t5_fatal", 64'(s_fat), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 0, 0, 0);
      chk("t5_no_entry", 64'(s_exc), 64'(0));
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] irq;
      irq = irq_req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) irq[b] = ~irq[b];
      end
      step(irq, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
